// File: rtl/regmap_pkg.sv
// Shared constants and types for the SPI register-map access arbiter.
// Config registers sit at the bottom of the map, status registers directly above.
package regmap_pkg;

  localparam int unsigned ADDR_WIDTH     = 7;
  localparam int unsigned DATA_WIDTH     = 8;
  localparam int unsigned NUM_CONFIG_REG = 96;
  localparam int unsigned NUM_STATUS_REG = 32;
  localparam int unsigned STATUS_BASE    = NUM_CONFIG_REG;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    PORT_SPI  = 1'b0,
    PORT_CORE = 1'b1
  } port_e;

  // SPI owns the config region, the core owns the status region.
  function automatic logic wr_permitted(input port_e port, input int unsigned addr,
                                        input int unsigned ncfg, input int unsigned nstat);
    if (port == PORT_SPI) return addr < ncfg;
    else                  return (addr >= ncfg) && (addr < ncfg + nstat);
  endfunction

endpackage

// File: rtl/regmap_rr_arb.sv
// Two-requester round-robin arbiter: on a tie the port not granted last wins.
// last_grant only advances when the caller strobes update.
module regmap_rr_arb
  import regmap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  port_e last_grant;

  always_comb begin
    gnt = req;
    if (req == 2'b11)
      gnt = (last_grant == PORT_CORE) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_grant <= PORT_CORE;
    else if (update && (gnt != 2'b00))
      last_grant <= gnt[1] ? PORT_CORE : PORT_SPI;
  end

endmodule

// File: rtl/regmap_access_arbiter.sv
// Sequences SPI and core-side accesses onto the single-ported register storage
// through IDLE -> ISSUE -> RESP, with region write protection per port.
module regmap_access_arbiter #(
  parameter int unsigned ADDR_WIDTH     = regmap_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = regmap_pkg::DATA_WIDTH,
  parameter int unsigned NUM_CONFIG_REG = regmap_pkg::NUM_CONFIG_REG,
  parameter int unsigned NUM_STATUS_REG = regmap_pkg::NUM_STATUS_REG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_req,
  input  logic                  spi_we,
  input  logic [ADDR_WIDTH-1:0] spi_addr,
  input  logic [DATA_WIDTH-1:0] spi_wdata,
  output logic                  spi_ack,
  output logic                  spi_err,
  output logic [DATA_WIDTH-1:0] spi_rdata,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_ack,
  output logic                  core_err,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  import regmap_pkg::*;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } acc_t;

  state_e     state, state_nx;
  port_e      gnt_port;
  acc_t       cur;
  logic       cur_perm;
  logic [1:0] elig, gnt;
  logic       take, issue_act;
  acc_t       sel;
  port_e      sel_port;

  // A port cannot be re-granted in the cycle its own ack is showing.
  assign elig = {core_req & ~core_ack, spi_req & ~spi_ack};
  assign take = (state == IDLE) && (elig != 2'b00);

  regmap_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (elig),
    .update (take),
    .gnt    (gnt)
  );

  always_comb begin
    sel_port = gnt[1] ? PORT_CORE : PORT_SPI;
    sel      = gnt[1] ? acc_t'{core_we, core_addr, core_wdata}
                      : acc_t'{spi_we, spi_addr, spi_wdata};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Gated by rst_n so storage can never be written while reset is asserted.
  assign issue_act = (state == ISSUE) && rst_n;

  always_comb begin
    mem_en    = issue_act;
    mem_we    = issue_act & cur.we & cur_perm;
    mem_addr  = issue_act ? cur.addr  : '0;
    mem_wdata = issue_act ? cur.wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_port   <= PORT_SPI;
      cur        <= '0;
      cur_perm   <= 1'b0;
      spi_ack    <= 1'b0;
      spi_err    <= 1'b0;
      spi_rdata  <= '0;
      core_ack   <= 1'b0;
      core_err   <= 1'b0;
      core_rdata <= '0;
    end else begin
      state    <= state_nx;
      spi_ack  <= 1'b0;
      spi_err  <= 1'b0;
      core_ack <= 1'b0;
      core_err <= 1'b0;
      if (take) begin
        gnt_port <= sel_port;
        cur      <= sel;
        cur_perm <= wr_permitted(sel_port, 32'(sel.addr), NUM_CONFIG_REG, NUM_STATUS_REG);
      end
      if (state == RESP) begin
        if (gnt_port == PORT_SPI) begin
          spi_ack <= 1'b1;
          spi_err <= cur.we & ~cur_perm;
          if (!cur.we) spi_rdata <= mem_rdata;
        end else begin
          core_ack <= 1'b1;
          core_err <= cur.we & ~cur_perm;
          if (!cur.we) core_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_regmap_access_arbiter.sv
// Scoreboard bench: expected rdata/err pushed per port at request time, popped on ack.
module tb_regmap_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_req = 0, spi_we = 0, core_req = 0, core_we = 0;
  logic [6:0] spi_addr = '0, core_addr = '0;
  logic [7:0] spi_wdata = '0, core_wdata = '0;
  logic       spi_ack, spi_err, core_ack, core_err;
  logic [7:0] spi_rdata, core_rdata;
  logic       mem_en, mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;

  always #5 clk = ~clk;

  regmap_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_ack(spi_ack), .spi_err(spi_err), .spi_rdata(spi_rdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_err(core_err), .core_rdata(core_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Storage: synchronous write, read data one cycle after mem_en.
  logic [7:0] store [128] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) store[mem_addr] <= mem_wdata;
      mem_rdata <= store[mem_addr];
    end
  end

  typedef struct { logic [7:0] rd; logic err; } exp_t;
  exp_t       spi_q[$], core_q[$];
  logic [7:0] ref_mem [128] = '{default: 8'h00};
  logic [7:0] exp_rd [2] = '{8'h00, 8'h00};
  int         n_cmp = 0, n_bad = 0;
  int         we_cnt = 0;
  logic [6:0] we_addr = '0;
  logic [7:0] we_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mem_we) begin
      we_cnt++;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
    if (!rst_n) chk("rst_mem_gate", {30'd0, mem_en, mem_we}, 0);
    if (spi_ack) begin
      if (spi_q.size() == 0) chk("spi_spurious_ack", 1, 0);
      else begin
        e = spi_q.pop_front();
        chk("spi_rdata", {24'd0, spi_rdata}, {24'd0, e.rd});
        chk("spi_err", {31'd0, spi_err}, {31'd0, e.err});
      end
    end
    if (core_ack) begin
      if (core_q.size() == 0) chk("core_spurious_ack", 1, 0);
      else begin
        e = core_q.pop_front();
        chk("core_rdata", {24'd0, core_rdata}, {24'd0, e.rd});
        chk("core_err", {31'd0, core_err}, {31'd0, e.err});
      end
    end
  end

  // Compute the expected response from the reference map and raise the request.
  task automatic start(input int p, input logic we, input logic [6:0] a, input logic [7:0] d);
    logic perm, err;
    exp_t e;
    perm = !we || ((p == 0) ? (a < 7'd96) : (a >= 7'd96));
    err  = we && !perm;
    if (!we) exp_rd[p] = ref_mem[a];
    else if (perm) ref_mem[a] = d;
    e.rd = exp_rd[p];
    e.err = err;
    if (p == 0) begin
      spi_q.push_back(e);
      spi_we = we; spi_addr = a; spi_wdata = d; spi_req = 1'b1;
    end else begin
      core_q.push_back(e);
      core_we = we; core_addr = a; core_wdata = d; core_req = 1'b1;
    end
  endtask

  task automatic access(input int p, input logic we, input logic [6:0] a, input logic [7:0] d,
                        output int cyc);
    logic got;
    @(posedge clk); #1;
    start(p, we, a, d);
    cyc = 0;
    got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? spi_ack : core_ack) begin
        cyc = i;
        got = 1'b1;
        if (p == 0) spi_req = 1'b0; else core_req = 1'b0;
      end
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
      spi_req = 1'b0; core_req = 1'b0;
    end
  endtask

  task automatic pair(input logic [6:0] sa, input logic [6:0] ca, output int cs, output int cc);
    @(posedge clk); #1;
    start(0, 1'b0, sa, 8'h00);
    start(1, 1'b0, ca, 8'h00);
    cs = 0; cc = 0;
    for (int i = 1; i <= 30 && (cs == 0 || cc == 0); i++) begin
      @(negedge clk);
      if (spi_ack && cs == 0)  begin cs = i; spi_req = 1'b0; end
      if (core_ack && cc == 0) begin cc = i; core_req = 1'b0; end
    end
    if (cs == 0 || cc == 0) begin
      chk("pair_timeout", 0, 1);
      spi_req = 1'b0; core_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_acks", {28'd0, spi_ack, spi_err, core_ack, core_err}, 0);
    chk("rst_rdata", {16'd0, spi_rdata, core_rdata}, 0);
    chk("rst_mem", {15'd0, mem_en, mem_we, mem_addr, mem_wdata}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, cs, cc, w0;
    do_reset();

    // Read latency from sampling edge to ack cycle.
    access(0, 1'b0, 7'h00, 8'h00, cyc);
    chk("t1_latency", cyc, 4);

    w0 = we_cnt;
    access(0, 1'b1, 7'h12, 8'hA5, cyc);
    chk("t2_we_pulses", we_cnt - w0, 1);
    chk("t2_we_addr", {25'd0, we_addr}, 32'h12);
    chk("t2_we_data", {24'd0, we_data}, 32'hA5);
    access(1, 1'b0, 7'h12, 8'h00, cyc);

    // Tie after reset goes to SPI; core follows right after the SPI ack cycle.
    do_reset();
    pair(7'h05, 7'h65, cs, cc);
    chk("t3_spi_first", cs, 4);
    chk("t3_core_next", cc, 7);
    // A lone SPI grant makes SPI the last winner, so the next tie goes to core.
    access(0, 1'b0, 7'h05, 8'h00, cyc);
    pair(7'h05, 7'h65, cs, cc);
    chk("t3b_core_first", cc, 4);
    chk("t3b_spi_next", cs, 7);

    access(1, 1'b1, 7'h70, 8'hFF, cyc);
    w0 = we_cnt;
    access(0, 1'b1, 7'h70, 8'h3C, cyc);
    chk("t4_denied_no_we", we_cnt - w0, 0);
    access(0, 1'b0, 7'h70, 8'h00, cyc);

    w0 = we_cnt;
    access(1, 1'b1, 7'h10, 8'h55, cyc);
    chk("t5_denied_no_we", we_cnt - w0, 0);
    access(0, 1'b0, 7'h10, 8'h00, cyc);

    // Reset during ISSUE aborts the write; no response is queued for it.
    access(0, 1'b1, 7'h20, 8'h11, cyc);
    w0 = we_cnt;
    @(posedge clk); #1;
    spi_we = 1'b1; spi_addr = 7'h20; spi_wdata = 8'h77; spi_req = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    spi_req = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    @(negedge clk);
    chk("t6_issue_gated", {30'd0, mem_en, mem_we}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_outs", {spi_ack, core_ack, spi_err, core_err, spi_rdata, core_rdata, 4'd0}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_no_write", we_cnt - w0, 0);
    access(0, 1'b0, 7'h20, 8'h00, cyc);

    repeat (3) @(negedge clk);
    chk("queues_drained", spi_q.size() + core_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regmap_access_arbiter.md
# regmap_access_arbiter

Arbitrates single-ported access to the 128-entry SPI register map storage between the SPI slave front-end and an internal core-side port. Config registers occupy 0x00–0x5F and status registers 0x60–0x7F. The block sequences each access through a fixed three-state FSM with 2-way round-robin arbitration. It also enforces region write protection: the SPI port may write config only, and the core port may write status only.

## Interface
- ADDR_WIDTH, 7, register address width
- DATA_WIDTH, 8, register data width
- NUM_CONFIG_REG, 96, config registers at 0..NUM_CONFIG_REG-1
- NUM_STATUS_REG, 32, status registers directly above config

One clock; reset is synchronous and active-low.

- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- spi_req  in  1  SPI access request; hold with fields stable until spi_ack
- spi_we  in  1  1 = write, 0 = read
- spi_addr  in  ADDR_WIDTH  target register
- spi_wdata  in  DATA_WIDTH  write data
- spi_ack  out  1  one-cycle completion pulse
- spi_err  out  1  protection violation, pulses with spi_ack
- spi_rdata  out  DATA_WIDTH  read data, held until the next SPI read ack
- core_req, core_we, core_addr, core_wdata  in  same as the SPI port  core-side request
- core_ack, core_err  out  1  same as the SPI port
- core_rdata  out  DATA_WIDTH  same as the SPI port
- mem_en  out  1  storage access strobe
- mem_we  out  1  storage write enable
- mem_addr  out  ADDR_WIDTH  storage address
- mem_wdata  out  DATA_WIDTH  storage write data
- mem_rdata  in  DATA_WIDTH  storage read data, valid the cycle after mem_en

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE → ISSUE when any eligible req is sampled high. The grant is registered.
  - A port's req is ineligible in the cycle its own ack is high.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_en=1, with mem_addr, mem_wdata and mem_we driven from the granted port.
  - mem_we = granted we AND write-permitted.
  - Always → RESP.
- RESP:
  - Capture mem_rdata into the granted port's rdata (reads only; writes leave rdata unchanged).
  - Register ack=1, and register err=1 if the write was denied.
  - Always → IDLE.
- Write permission:
  - SPI: addr < NUM_CONFIG_REG.
  - Core: NUM_CONFIG_REG ≤ addr < NUM_CONFIG_REG+NUM_STATUS_REG.
  - Reads are always permitted on both ports.
- Denied write:
  - The storage read cycle still occurs (mem_en=1, mem_we=0).
  - rdata is unchanged.
  - ack and err pulse together.
- Arbitration:
  - With a single eligible req, that port is granted.
  - When both are eligible, the port not granted last wins.
  - last_grant resets to core, so SPI wins the first tie.
- mem_en, mem_we, mem_addr and mem_wdata are 0 outside ISSUE.

## Timing
- A req sampled high at edge E0 (in IDLE): ISSUE after E0, RESP after E1, ack high for one cycle after E2. Latency is 3 cycles.
- Throughput is 1 access per 3 cycles.
- Back-to-back: state is IDLE during the ack cycle. The other port's pending req is sampled at the end of that cycle.
- The requester must drop or update req by the ack cycle. A req still high in the cycle after ack is a new request.
- Reset values: state=IDLE, all ack/err=0, both rdata=0, last_grant=core, all mem_* outputs=0.
- mem_en and mem_we are gated by rst_n, so storage is never written in a cycle with rst_n low.
- Reset mid-transaction aborts it: no ack is ever issued for it.

## Structure
- Shared package regmap_pkg contains:
  - ADDR_WIDTH, DATA_WIDTH, NUM_CONFIG_REG, NUM_STATUS_REG
  - STATUS_BASE = NUM_CONFIG_REG
  - state enum {IDLE, ISSUE, RESP}
  - port-id enum {PORT_SPI, PORT_CORE}
- One sub-module, regmap_rr_arb: 2-requester round-robin with a last_grant register, an update strobe, and a one-hot grant output.
- The FSM, permission decode and response registers live in the top module.

## Test plan
1. Reset, storage preloaded with 0x00; SPI read 0x00 → spi_ack exactly 3 cycles after sampling, spi_rdata=0x00, spi_err=0.
2. SPI write 0x12=0xA5, then core read 0x12 → one mem_we pulse with mem_addr=0x12, mem_wdata=0xA5; core_rdata=0xA5, core_err=0.
3. After reset, SPI read 0x05 and core read 0x65 raised in the same cycle → spi_ack first, core_ack 3 cycles later. A second simultaneous pair is granted core first.
4. Core write 0x70=0xFF, then SPI write 0x70=0x3C → spi_err=1 with spi_ack and mem_we never high for the SPI write; SPI read 0x70 returns 0xFF.
5. Core write 0x10=0x55 → core_err=1, mem_we=0; SPI read 0x10 returns its prior value.
6. rst_n low during ISSUE of SPI write 0x20=0x77 → mem_we=0 in that cycle, all outputs at reset values after the edge, no spi_ack; read 0x20 returns its old value.
